// File: rtl/alarm_pkg.sv
// alarm_pkg: shared types and calendar constants for the alarm bank.
//   alarm_state_t : per-channel ring/snooze state
//   alarm_cfg_t   : one channel's programmable settings
package alarm_pkg;

   typedef enum logic [1:0] {A_IDLE, A_RING, A_SNOOZE} alarm_state_t;

   localparam int DAYS = 7;
   localparam int MINS = 60;
   localparam int HRS  = 24;

   typedef struct packed {
      logic [6:0] amin;
      logic [6:0] ahrs;
      logic [6:0] daymask;
      logic       armed;
   } alarm_cfg_t;

endpackage

// File: rtl/alarm_chan.sv
// alarm_chan: one alarm channel -- settings registers plus the
// ring/snooze/auto-off state machine, advanced by the minute tick.
//   clk, reset        : clock, asynchronous active-high reset
//   tick_min          : one-cycle minute pulse, tmin/thrs/tday valid with it
//   tmin, thrs, tday  : current time of day
//   wr, wr_cfg        : load new settings into this channel
//   snooze, dismiss   : user pulses shared by all channels
//   ringing, snoozed  : state decode
//   missed            : sticky auto-off flag
module alarm_chan
   import alarm_pkg::*;
#(
   parameter int RING_MIN   = 5,
   parameter int SNOOZE_MIN = 9,
   parameter int MAX_SNOOZE = 3
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       tick_min,
   input  logic [6:0] tmin,
   input  logic [6:0] thrs,
   input  logic [6:0] tday,
   input  logic       wr,
   input  alarm_cfg_t wr_cfg,
   input  logic       snooze,
   input  logic       dismiss,
   output logic       ringing,
   output logic       snoozed,
   output logic       missed
);

   localparam logic [3:0] RING_LEN = 4'(RING_MIN);
   localparam logic [3:0] SNZ_LEN  = 4'(SNOOZE_MIN);
   localparam logic [2:0] SNZ_MAX  = 3'(MAX_SNOOZE);

   alarm_cfg_t   cfg, cfg_nxt;
   alarm_state_t state, state_nxt;
   logic [3:0]   min_cnt, min_cnt_nxt;
   logic [2:0]   snz_cnt, snz_cnt_nxt;
   logic         missed_nxt;
   logic         match;

   // Day range is checked first so an invalid day never indexes the mask.
   assign match = cfg.armed && (tmin == cfg.amin) && (thrs == cfg.ahrs) &&
                  (tday <= 7'(DAYS - 1)) && cfg.daymask[tday[2:0]];

   always_comb begin
      // NOTE: every variable gets a default first so no path leaves it unassigned (no latches).
      cfg_nxt     = cfg;
      state_nxt   = state;
      min_cnt_nxt = min_cnt;
      snz_cnt_nxt = snz_cnt;
      missed_nxt  = missed;

      if (wr) begin
         // A write overrides everything else this cycle, including a tick.
         cfg_nxt     = wr_cfg;
         state_nxt   = A_IDLE;
         min_cnt_nxt = '0;
         snz_cnt_nxt = '0;
         missed_nxt  = 1'b0;
      end else begin
         if (dismiss) missed_nxt = 1'b0;
         unique case (state)
            A_IDLE: begin
               if (tick_min && match) begin
                  state_nxt   = A_RING;
                  min_cnt_nxt = '0;
                  snz_cnt_nxt = '0;
               end
            end
            A_RING: begin
               if (dismiss) begin
                  state_nxt = A_IDLE;
               end else if (snooze && (snz_cnt < SNZ_MAX)) begin
                  state_nxt   = A_SNOOZE;
                  min_cnt_nxt = '0;
                  snz_cnt_nxt = snz_cnt + 3'd1;
               end else if (tick_min) begin
                  if (min_cnt + 4'd1 == RING_LEN) begin
                     state_nxt  = A_IDLE;
                     missed_nxt = 1'b1;
                  end else begin
                     min_cnt_nxt = min_cnt + 4'd1;
                  end
               end
            end
            A_SNOOZE: begin
               if (dismiss) begin
                  state_nxt = A_IDLE;
               end else if (tick_min) begin
                  if (min_cnt + 4'd1 == SNZ_LEN) begin
                     state_nxt   = A_RING;
                     min_cnt_nxt = '0;
                  end else begin
                     min_cnt_nxt = min_cnt + 4'd1;
                  end
               end
            end
            default: state_nxt = A_IDLE;
         endcase
      end
   end

   // NOTE: settings registers are reset too, so a channel can never ring from power-up garbage.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cfg     <= '0;
         state   <= A_IDLE;
         min_cnt <= '0;
         snz_cnt <= '0;
         missed  <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so all registers update together on the edge.
         cfg     <= cfg_nxt;
         state   <= state_nxt;
         min_cnt <= min_cnt_nxt;
         snz_cnt <= snz_cnt_nxt;
         missed  <= missed_nxt;
      end
   end

   assign ringing = (state == A_RING);
   assign snoozed = (state == A_SNOOZE);

endmodule

// File: rtl/alarm_bank.sv
// alarm_bank: N independently programmable alarms with weekday masks,
// snooze and auto-off, driven by the time-of-day counter's minute tick.
//   clk, reset                   : clock, asynchronous active-high reset
//   tick_min, tmin, thrs, tday   : minute pulse and current time
//   wr_en, wr_sel, wr_*          : program one channel
//   snooze, dismiss              : shared user pulses
//   buzz                         : any channel ringing
//   ringing, snoozed, missed     : per-channel status
module alarm_bank
   import alarm_pkg::*;
#(
   parameter  int N_ALARMS   = 4,
   parameter  int RING_MIN   = 5,
   parameter  int SNOOZE_MIN = 9,
   parameter  int MAX_SNOOZE = 3,
   localparam int SEL_W      = (N_ALARMS > 1) ? $clog2(N_ALARMS) : 1
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                tick_min,
   input  logic [6:0]          tmin,
   input  logic [6:0]          thrs,
   input  logic [6:0]          tday,
   input  logic                wr_en,
   input  logic [SEL_W-1:0]    wr_sel,
   input  logic [6:0]          wr_amin,
   input  logic [6:0]          wr_ahrs,
   input  logic [6:0]          wr_daymask,
   input  logic                wr_arm,
   input  logic                snooze,
   input  logic                dismiss,
   output logic                buzz,
   output logic [N_ALARMS-1:0] ringing,
   output logic [N_ALARMS-1:0] snoozed,
   output logic [N_ALARMS-1:0] missed
);

   alarm_cfg_t wr_cfg;

   assign wr_cfg = '{amin: wr_amin, ahrs: wr_ahrs, daymask: wr_daymask, armed: wr_arm};

   for (genvar i = 0; i < N_ALARMS; i++) begin : g_chan
      // A wr_sel beyond the last channel matches no instance and is dropped.
      logic wr_hit;
      assign wr_hit = wr_en && (wr_sel == SEL_W'(i));

      alarm_chan #(
         .RING_MIN   (RING_MIN),
         .SNOOZE_MIN (SNOOZE_MIN),
         .MAX_SNOOZE (MAX_SNOOZE)
      ) u_chan (
         .clk      (clk),
         .reset    (reset),
         .tick_min (tick_min),
         .tmin     (tmin),
         .thrs     (thrs),
         .tday     (tday),
         .wr       (wr_hit),
         .wr_cfg   (wr_cfg),
         .snooze   (snooze),
         .dismiss  (dismiss),
         .ringing  (ringing[i]),
         .snoozed  (snoozed[i]),
         .missed   (missed[i])
      );
   end

   // Decoded from channel state only, so reset drops the buzzer without a clock.
   assign buzz = |ringing;

endmodule

// File: doc/alarm_bank.md
# alarm_bank

Parametrised multi-channel alarm controller: the successor to the single combinational minute-match alarm. It holds N independently programmable alarms, each with a weekday mask, and runs a per-channel ring/snooze/auto-off state machine clocked by a one-per-minute tick. It sits beside the time-of-day counter: it consumes its minute/hour/day outputs and drives the buzzer plus per-channel status to the display logic.

## Interface
- N_ALARMS, 4: number of alarm channels (1..8)
- RING_MIN, 5: minutes a channel rings before auto-off (1..15)
- SNOOZE_MIN, 9: snooze length in minutes (1..15)
- MAX_SNOOZE, 3: snoozes allowed per ring episode (0..7); 0 disables snooze
- clk  in  1  system clock; one clock, all state on its rising edge
- reset  in  1  asynchronous, active-high; clears every register immediately
- tick_min  in  1  one-cycle pulse; tmin/thrs/tday carry the new minute in that cycle
- tmin, thrs, tday  in  7 each  current minute 0..59, hour 0..23, day 0..6
- wr_en  in  1  program strobe
- wr_sel  in  $clog2(N_ALARMS) (min 1)  channel to program
- wr_amin, wr_ahrs  in  7 each  alarm minute/hour
- wr_daymask  in  7  bit d set = alarm active on day d
- wr_arm  in  1  channel armed after write
- snooze  in  1  one-cycle pulse, applies to every RING channel
- dismiss  in  1  one-cycle pulse, applies to every RING or SNOOZE channel
- buzz  out  1  OR of all channels in RING
- ringing  out  N_ALARMS  per-channel RING status
- snoozed  out  N_ALARMS  per-channel SNOOZE status
- missed  out  N_ALARMS  sticky: channel auto-offed without dismiss; cleared by dismiss or by writing that channel

## Operation
- Per-channel registers: amin, ahrs, daymask, armed, state, min_cnt (4 b), snz_cnt (3 b).
- States: IDLE, RING, SNOOZE.
- Match = armed && tmin==amin && thrs==ahrs && tday<=6 && daymask[tday]; evaluated only on tick_min.
- IDLE -> RING on tick_min && match; min_cnt<=0, snz_cnt<=0.
- RING: on tick_min, min_cnt++; when it reaches RING_MIN -> IDLE, missed<=1. On snooze, if snz_cnt<MAX_SNOOZE -> SNOOZE, min_cnt<=0, snz_cnt++; otherwise ignored. On dismiss -> IDLE.
- SNOOZE: on tick_min, min_cnt++; when it reaches SNOOZE_MIN -> RING, min_cnt<=0; snz_cnt kept. On dismiss -> IDLE.
- Matches arriving in RING/SNOOZE are ignored (no restart).
- Write to channel k: loads fields, forces k to IDLE, clears min_cnt/snz_cnt/missed[k]; other channels unaffected. An out-of-range wr_sel is ignored.
- Same-cycle priority per channel: write > dismiss > snooze > tick_min. A tick coinciding with a write does not match the new settings in that cycle.
- Snooze/dismiss with no channel in RING/SNOOZE: no effect.

## Timing
- Reset values: all states IDLE, armed=0, amin/ahrs/daymask=0, counters 0, buzz=0, ringing=0, snoozed=0, missed=0.
- All outputs are decoded directly from registers; no input-to-output combinational path.
- Latency: tick_min in cycle k with match -> ringing/buzz high from cycle k+1.
- snooze/dismiss in cycle k -> status change visible in k+1.
- Reset asserted mid-ring: buzz drops asynchronously, with no wait for clk.
- Ring length is exactly RING_MIN ticks after the entry tick; snooze length is exactly SNOOZE_MIN ticks.

## Structure
- alarm_pkg: typedef enum logic [1:0] alarm_state_t {A_IDLE, A_RING, A_SNOOZE}; constants DAYS=7, MINS=60, HRS=24.
- Sub-module alarm_chan: one channel's registers and FSM, instantiated N_ALARMS times via generate. The top level does write decode and the buzz/status OR-reduction.

## Test plan
- Program ch0 07:30 daymask 7'b0111110, armed; tick at 07:30 day 1 -> ringing[0]=1 and buzz=1 next cycle; same time on day 0 -> no ring.
- Ring ch0, apply no inputs for 5 ticks -> IDLE after the 5th tick, missed[0]=1; a dismiss then clears missed[0].
- Ring ch1, snooze -> snoozed[1]=1 and buzz=0; after 9 ticks -> ringing[1]=1. Snooze 3 times, then a 4th snooze is ignored and it stays in RING.
- ch0 and ch2 both set to 06:00 -> both ring; one dismiss -> both IDLE and buzz=0.
- Write ch0 while it is ringing -> IDLE next cycle; write plus dismiss plus tick in the same cycle -> write wins, no ring.
- Assert reset during RING in the middle of a clock period -> buzz=0 before the next edge; all outputs stay 0 until the next match.
